time_pulse_gen: RTL

Upstream timing sequencer for the service-gate stage. It generates the twelve memory-cycle time pulses T01–T12 and, within each time pulse, the four active-low phase strobes CT_n, RT_n, WT_n and TT_n. The service gates and the central-register gating consume these strobes directly. The block also implements restart (GOJAM), single-stepping (MSTP/MSTRT) and an end-of-memory-cycle-time (MCT) strobe.

---
 rtl/agc_timing_pkg.sv | 26 ++
 rtl/tp_decode.sv | 29 ++
 rtl/time_pulse_gen.sv | 135 +++++++++++++
 3 files changed

// File: rtl/agc_timing_pkg.sv
// Shared timing types for the memory-cycle sequencer: time-pulse/phase widths,
// phase encoding and the single-step FSM states.
package agc_timing_pkg;

    localparam int NUM_TP = 12;
    localparam int NUM_PH = 4;

    typedef logic [3:0] tp_t;
    typedef logic [1:0] ph_t;

    typedef enum logic [1:0] {
        PH_CT = 2'd0,
        PH_RT = 2'd1,
        PH_WT = 2'd2,
        PH_TT = 2'd3
    } phase_e;

    typedef enum logic {
        ST_RUN     = 1'b0,
        ST_STOPPED = 1'b1
    } step_state_e;

    localparam tp_t TP_FIRST = 4'd1;
    localparam tp_t TP_LAST  = 4'd12;

endpackage

// File: rtl/tp_decode.sv
// Combinational decode of (time pulse, phase, stopped) into the active-low
// T pulses and phase strobes; everything is forced high while halted.
module tp_decode
    import agc_timing_pkg::*;
(
    input  logic              stopped,
    input  tp_t               tp,
    input  ph_t               ph,
    output logic [NUM_TP-1:0] T_n,
    output logic              CT_n,
    output logic              RT_n,
    output logic              WT_n,
    output logic              TT_n
);

    generate
        for (genvar gi = 0; gi < NUM_TP; gi++) begin : g_tp
            assign T_n[gi] = stopped | (tp != tp_t'(gi + 1));
        end
    endgenerate

    // RT spans both the read and write phases so the read path stays open
    // while the write strobe fires.
    assign CT_n = stopped | (ph != PH_CT);
    assign RT_n = stopped | !((ph == PH_RT) || (ph == PH_WT));
    assign WT_n = stopped | (ph != PH_WT);
    assign TT_n = stopped | (ph != PH_TT);

endmodule

// File: rtl/time_pulse_gen.sv
// Memory-cycle sequencer: T01..T12 time pulses with four phases each, plus
// GOJAM restart, MSTP/MSTRT single-stepping and the end-of-cycle MCT pulse.
module time_pulse_gen
    import agc_timing_pkg::*;
#(
    parameter int TICKS_PER_PHASE = 1
) (
    input  logic        SIM_CLK,
    input  logic        SIM_RST,
    input  logic        CLK_EN,
    input  logic        GOJAM,
    input  logic        MSTP,
    input  logic        MSTRT,
    output logic [11:0] T_n,
    output logic        CT_n,
    output logic        RT_n,
    output logic        WT_n,
    output logic        TT_n,
    output logic        MCT,
    output logic        STOPPED
);

    localparam int TICK_W = (TICKS_PER_PHASE > 1) ? $clog2(TICKS_PER_PHASE) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICKS_PER_PHASE - 1);

    tp_t               tp_reg, tp_next;
    ph_t               ph_reg, ph_next;
    logic [TICK_W-1:0] tick_reg, tick_next;
    step_state_e       state_reg, state_next;
    logic              mstrt_prev_reg, mstrt_prev_next;
    logic              mct_next;
    logic              mstrt_rise;

    logic [11:0] dec_t_n;
    logic        dec_ct_n, dec_rt_n, dec_wt_n, dec_tt_n;

    // The edge detector only samples on enabled ticks so an edge landing on
    // a disabled cycle is still seen on the next enabled one.
    assign mstrt_rise = MSTRT & ~mstrt_prev_reg;

    always_comb begin
        tp_next         = tp_reg;
        ph_next         = ph_reg;
        tick_next       = tick_reg;
        state_next      = state_reg;
        mct_next        = 1'b0;
        mstrt_prev_next = CLK_EN ? MSTRT : mstrt_prev_reg;

        if (GOJAM) begin
            tp_next    = TP_FIRST;
            ph_next    = PH_CT;
            tick_next  = '0;
            state_next = ST_RUN;
        end else if (CLK_EN) begin
            case (state_reg)
                ST_RUN: begin
                    if (tick_reg == TICK_LAST) begin
                        tick_next = '0;
                        if (ph_reg == PH_TT) begin
                            ph_next = PH_CT;
                            if (tp_reg == TP_LAST) begin
                                tp_next  = TP_FIRST;
                                mct_next = 1'b1;
                                if (MSTP) begin
                                    state_next = ST_STOPPED;
                                end
                            end else begin
                                tp_next = tp_reg + 4'd1;
                            end
                        end else begin
                            ph_next = ph_reg + 2'd1;
                        end
                    end else begin
                        tick_next = tick_reg + TICK_W'(1);
                    end
                end
                ST_STOPPED: begin
                    if (mstrt_rise || !MSTP) begin
                        state_next = ST_RUN;
                        tp_next    = TP_FIRST;
                        ph_next    = PH_CT;
                        tick_next  = '0;
                    end
                end
                default: begin
                    state_next = ST_RUN;
                end
            endcase
        end
    end

    // Decoding the next state lets the output registers load on the same
    // edge as the counters.
    tp_decode u_decode (
        .stopped (state_next == ST_STOPPED),
        .tp      (tp_next),
        .ph      (ph_next),
        .T_n     (dec_t_n),
        .CT_n    (dec_ct_n),
        .RT_n    (dec_rt_n),
        .WT_n    (dec_wt_n),
        .TT_n    (dec_tt_n)
    );

    always_ff @(posedge SIM_CLK) begin
        if (SIM_RST) begin
            tp_reg         <= TP_FIRST;
            ph_reg         <= PH_CT;
            tick_reg       <= '0;
            state_reg      <= ST_RUN;
            mstrt_prev_reg <= 1'b0;
            T_n            <= 12'hFFE;
            CT_n           <= 1'b0;
            RT_n           <= 1'b1;
            WT_n           <= 1'b1;
            TT_n           <= 1'b1;
            MCT            <= 1'b0;
            STOPPED        <= 1'b0;
        end else begin
            tp_reg         <= tp_next;
            ph_reg         <= ph_next;
            tick_reg       <= tick_next;
            state_reg      <= state_next;
            mstrt_prev_reg <= mstrt_prev_next;
            T_n            <= dec_t_n;
            CT_n           <= dec_ct_n;
            RT_n           <= dec_rt_n;
            WT_n           <= dec_wt_n;
            TT_n           <= dec_tt_n;
            MCT            <= mct_next;
            STOPPED        <= (state_next == ST_STOPPED);
        end
    end

endmodule
